// File: rtl/cache.sv
// ---------------------------------------------------------------------------
// cache
//
// Small PID-tagged, page-granular data cache sitting between a loader /
// requester and backing memory. A process streams 12-bit words in one at a
// time; each word lands at the next sequential virtual address for that PID.
// Reads take a 12-bit virtual address and return the stored word, or raise a
// page fault when the page is not resident.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-high reset
//   cmd        - 00 idle, 01 read, 10 write, 11 reserved (acts as idle)
//   datavalid  - write-word strobe, qualifies datain when cmd = 10
//   datain     - write data (cmd = 10) or virtual read address (cmd = 01)
//   PID        - process ID tagging the access
//   pagefault  - one-cycle pulse alongside outvalid when a read misses
//   dataout    - read data, meaningful while outvalid = 1
//   outvalid   - one-cycle read-completion pulse (hit or miss)
//   wd         - write-ready, cache accepts a write word this cycle
// ---------------------------------------------------------------------------
module cache #(
   parameter int LINES      = 4,
   parameter int LINE_WORDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  cmd,
   input  logic        datavalid,
   input  logic [11:0] datain,
   input  logic [3:0]  PID,
   output logic        pagefault,
   output logic [11:0] dataout,
   output logic        outvalid,
   output logic        wd
);

   localparam int OFFSET_W = $clog2(LINE_WORDS);
   localparam int VPAGE_W  = 12 - OFFSET_W;
   localparam int LINE_W   = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int INDEX_W  = LINE_W + OFFSET_W;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      LOOKUP,
      RESP
   } state_t;

   state_t state;

   // Per-line tags and the data array
   logic [LINES-1:0]   valid;
   logic [3:0]         pid_tag   [LINES];
   logic [VPAGE_W-1:0] vpage_tag [LINES];
   logic [11:0]        mem       [LINES*LINE_WORDS];

   // Write bookkeeping
   logic [11:0]        wr_cnt;
   logic [3:0]         last_pid;
   logic [LINE_W-1:0]  rep_ptr;

   // Captured read request and lookup result
   logic [11:0]        req_addr;
   logic [3:0]         req_pid;
   logic               lk_hit;
   logic [11:0]        rd_word;

   // Combinational helpers
   logic               accept_wr;
   logic               accept_rd;
   logic [11:0]        wr_addr;
   logic [VPAGE_W-1:0] wr_vpage;
   logic               wr_hit;
   logic [LINE_W-1:0]  wr_hit_line;
   logic [LINE_W-1:0]  wr_line;
   logic [INDEX_W-1:0] wr_index;
   logic               rd_hit;
   logic [LINE_W-1:0]  rd_line;
   logic [INDEX_W-1:0] rd_index;

   // Requests are only taken while wd is high. wd is low on the first cycle
   // out of reset even though the FSM is already in IDLE, so gating on wd
   // keeps that cycle quiet and ties acceptance to what the requester sees.
   // A PID change restarts the sequential address stream at zero for the
   // word being accepted now, not just for the following one.
   always_comb begin
      accept_wr = (state == IDLE) && wd && (cmd == 2'b10) && datavalid;
      accept_rd = (state == IDLE) && wd && (cmd == 2'b01);
      wr_addr   = (PID != last_pid) ? 12'd0 : wr_cnt;
      wr_vpage  = wr_addr[11:OFFSET_W];
   end

   // Fully associative tag search for the incoming write word: a line hits
   // only when it is valid and both PID and virtual page match. On a miss
   // the FIFO replacement pointer names the line to (re)allocate.
   always_comb begin
      wr_hit      = 1'b0;
      wr_hit_line = '0;
      for (int i = 0; i < LINES; i++) begin
         if (valid[i] && (pid_tag[i] == PID) && (vpage_tag[i] == wr_vpage)) begin
            wr_hit      = 1'b1;
            wr_hit_line = LINE_W'(i);
         end
      end
      wr_line  = wr_hit ? wr_hit_line : rep_ptr;
      wr_index = {wr_line, wr_addr[OFFSET_W-1:0]};
   end

   // Same search for the captured read request. The tags cannot change while
   // a read is in flight (no writes are accepted outside IDLE), so this stays
   // stable through LOOKUP and RESP.
   always_comb begin
      rd_hit  = 1'b0;
      rd_line = '0;
      for (int i = 0; i < LINES; i++) begin
         if (valid[i] && (pid_tag[i] == req_pid) &&
             (vpage_tag[i] == req_addr[11:OFFSET_W])) begin
            rd_hit  = 1'b1;
            rd_line = LINE_W'(i);
         end
      end
      rd_index = {rd_line, req_addr[OFFSET_W-1:0]};
   end

   // Data array: written on the accepting edge of a write, read every cycle
   // into rd_word. The word captured at the end of LOOKUP is what RESP
   // presents. The array is deliberately not reset; only the valid bits
   // decide what is resident.
   always_ff @(posedge clk) begin
      if (accept_wr) begin
         mem[wr_index] <= datain;
      end
      rd_word <= mem[rd_index];
   end

   // Main controller: state, tags, write counter, replacement pointer and all
   // registered outputs. outvalid/pagefault default low each cycle so they
   // pulse for exactly one cycle after RESP. A reset in the middle of a read
   // simply drops the request, so no completion pulse is ever produced.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         valid     <= '0;
         wr_cnt    <= '0;
         last_pid  <= '0;
         rep_ptr   <= '0;
         req_addr  <= '0;
         req_pid   <= '0;
         lk_hit    <= 1'b0;
         wd        <= 1'b0;
         outvalid  <= 1'b0;
         pagefault <= 1'b0;
         dataout   <= '0;
      end else begin
         outvalid  <= 1'b0;
         pagefault <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_wr) begin
                  state    <= WRITE;
                  wd       <= 1'b0;
                  last_pid <= PID;
                  wr_cnt   <= wr_addr + 12'd1;
                  if (!wr_hit) begin
                     valid[rep_ptr]     <= 1'b1;
                     pid_tag[rep_ptr]   <= PID;
                     vpage_tag[rep_ptr] <= wr_vpage;
                     rep_ptr            <= rep_ptr + LINE_W'(1);
                  end
               end else if (accept_rd) begin
                  state    <= LOOKUP;
                  wd       <= 1'b0;
                  req_addr <= datain;
                  req_pid  <= PID;
               end else begin
                  wd <= 1'b1;
               end
            end
            WRITE: begin
               state <= IDLE;
               wd    <= 1'b1;
            end
            LOOKUP: begin
               state  <= RESP;
               lk_hit <= rd_hit;
            end
            RESP: begin
               state     <= IDLE;
               wd        <= 1'b1;
               outvalid  <= 1'b1;
               pagefault <= !lk_hit;
               dataout   <= lk_hit ? rd_word : 12'd0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache.sv
// ---------------------------------------------------------------------------
// tb_cache
//
// Directed testbench for the cache. Writes word streams for several PIDs,
// reads them back with hand-computed expected values, forces page crossing
// and FIFO eviction, and aborts a read with reset.
// ---------------------------------------------------------------------------
module tb_cache;

   logic        clk;
   logic        rst;
   logic [1:0]  cmd;
   logic        datavalid;
   logic [11:0] datain;
   logic [3:0]  PID;
   logic        pagefault;
   logic [11:0] dataout;
   logic        outvalid;
   logic        wd;

   int assertCount = 0;
   int failCount   = 0;

   cache dut (
      .clk       (clk),
      .rst       (rst),
      .cmd       (cmd),
      .datavalid (datavalid),
      .datain    (datain),
      .PID       (PID),
      .pagefault (pagefault),
      .dataout   (dataout),
      .outvalid  (outvalid),
      .wd        (wd)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never completes
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check goes through here
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   // Drive all request inputs at once
   task automatic applyStimulus(input logic [1:0] c, input logic dv,
                                input logic [11:0] d, input logic [3:0] p);
      cmd       = c;
      datavalid = dv;
      datain    = d;
      PID       = p;
   endtask

   // Wait (bounded) for wd; leaves us 1 ns after a rising edge
   task automatic waitReady(input string tag);
      int n = 0;
      while (wd !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput(tag, {31'd0, wd}, 32'd1);
   endtask

   // One write word: pulse datavalid for one accepting edge, then expect wd low
   task automatic writeWord(input logic [3:0] p, input logic [11:0] d);
      waitReady("wr_ready");
      applyStimulus(2'b10, 1'b1, d, p);
      @(posedge clk);
      #1;
      applyStimulus(2'b00, 1'b0, 12'd0, p);
      checkOutput("wr_wd_drop", {31'd0, wd}, 32'd0);
   endtask

   // One read: request sampled at edge N, response visible after edge N+2,
   // gone again after edge N+3. datavalid is held high to show it is ignored.
   task automatic readCheck(input string tag, input logic [3:0] p,
                            input logic [11:0] addr, input logic expPf,
                            input logic [11:0] expData);
      waitReady({tag, "_ready"});
      applyStimulus(2'b01, 1'b1, addr, p);
      @(posedge clk);
      #1;
      applyStimulus(2'b00, 1'b0, 12'd0, p);
      checkOutput({tag, "_ov_n1"}, {31'd0, outvalid}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_ov_n2"}, {31'd0, outvalid}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_ov"}, {31'd0, outvalid}, 32'd1);
      checkOutput({tag, "_pf"}, {31'd0, pagefault}, {31'd0, expPf});
      checkOutput({tag, "_data"}, {20'd0, dataout}, {20'd0, expData});
      @(posedge clk);
      #1;
      checkOutput({tag, "_ov_end"}, {31'd0, outvalid}, 32'd0);
      checkOutput({tag, "_pf_end"}, {31'd0, pagefault}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(2'b00, 1'b0, 12'd0, 4'd0);

      // Reset held for two edges
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_wd", {31'd0, wd}, 32'd0);
      checkOutput("rst_ov", {31'd0, outvalid}, 32'd0);
      checkOutput("rst_pf", {31'd0, pagefault}, 32'd0);
      checkOutput("rst_data", {20'd0, dataout}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_wd_first", {31'd0, wd}, 32'd1);

      // PID 4: addresses 0..21 hold 100..121 (line 0)
      for (int i = 0; i < 22; i++) writeWord(4'd4, 12'(100 + i));

      // PID 3: counter restarts, addresses 0..20 hold 200..220 (line 1).
      // A datavalid burst with cmd=00 midway must not consume an address.
      for (int i = 0; i < 11; i++) writeWord(4'd3, 12'(200 + i));
      applyStimulus(2'b00, 1'b1, 12'd999, 4'd3);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ign_dv_wd", {31'd0, wd}, 32'd1);
      applyStimulus(2'b00, 1'b0, 12'd0, 4'd3);
      for (int i = 11; i < 21; i++) writeWord(4'd3, 12'(200 + i));

      readCheck("p3_a5", 4'd3, 12'h005, 1'b0, 12'd205);
      readCheck("p4_a5", 4'd4, 12'h005, 1'b0, 12'd105);
      readCheck("p4_a21", 4'd4, 12'h015, 1'b0, 12'd121);
      readCheck("p3_a20", 4'd3, 12'h014, 1'b0, 12'd220);
      readCheck("p5_miss", 4'd5, 12'h05F, 1'b1, 12'd0);
      readCheck("p3_vp1_miss", 4'd3, 12'h020, 1'b1, 12'd0);

      // Reserved command behaves as idle
      waitReady("cmd11_ready");
      applyStimulus(2'b11, 1'b1, 12'd7, 4'd4);
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("cmd11_wd", {31'd0, wd}, 32'd1);
         checkOutput("cmd11_ov", {31'd0, outvalid}, 32'd0);
      end
      applyStimulus(2'b00, 1'b0, 12'd0, 4'd4);

      // PID 4 again: counter restarts, addresses 0..160 hold 1000+addr.
      // 0..31 hit line 0; vpage1->line2, vpage2->line3, vpage3->line0,
      // vpage4->line1 (evicts PID 3), vpage5 (addr 160)->line2 (evicts vpage1).
      for (int i = 0; i <= 160; i++) writeWord(4'd4, 12'(1000 + i));

      readCheck("p3_evicted", 4'd3, 12'h005, 1'b1, 12'd0);
      readCheck("p4_a128", 4'd4, 12'h080, 1'b0, 12'd1128);
      readCheck("p4_a160", 4'd4, 12'h0A0, 1'b0, 12'd1160);
      readCheck("p4_a96", 4'd4, 12'h060, 1'b0, 12'd1096);
      readCheck("p4_a64", 4'd4, 12'h040, 1'b0, 12'd1064);
      readCheck("p4_vp1_evicted", 4'd4, 12'h020, 1'b1, 12'd0);
      readCheck("p4_vp0_evicted", 4'd4, 12'h000, 1'b1, 12'd0);

      // Reset while the read sits in LOOKUP: no completion pulse
      waitReady("mid_ready");
      applyStimulus(2'b01, 1'b0, 12'h080, 4'd4);
      @(posedge clk);
      #1;
      applyStimulus(2'b00, 1'b0, 12'd0, 4'd4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_ov1", {31'd0, outvalid}, 32'd0);
      checkOutput("mid_wd1", {31'd0, wd}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("mid_ov2", {31'd0, outvalid}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mid_ov3", {31'd0, outvalid}, 32'd0);
      checkOutput("mid_wd3", {31'd0, wd}, 32'd1);

      readCheck("post_rst_a0", 4'd4, 12'h000, 1'b1, 12'd0);
      readCheck("post_rst_a128", 4'd4, 12'h080, 1'b1, 12'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
